// File: rtl/rv32_inst_encoder_if.sv
// Request/response bus of the RV32I instruction encoder.
// The master drives requests and accepts encoded words; the slave is the encoder.
interface rv32_inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err
    );
endinterface

// File: rtl/rv32_inst_encoder.sv
// Turns operation requests into RV32I instruction words with byte addresses,
// one-deep registered output, program run-control that stops on EBREAK.
module rv32_inst_encoder #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    rv32_inst_encoder_if.slave bus,
    output logic               err_sticky,
    output logic               done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [4:0]        OP_EBREAK = 5'd16;
    localparam logic [31:0]       NOP_WORD  = 32'h00000013;

    state_t            state;
    logic              vld_p1;
    logic              err_p1;
    logic [31:0]       inst_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic [32:0]       enc_p0;

    function automatic logic fits(input logic signed [31:0] v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Returns {err, word}; out-of-range immediates still produce a word from the truncated bits.
    function automatic logic [32:0] encode(input logic [4:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic signed [31:0] imm);
        logic [31:0] w;
        logic        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        w  = NOP_WORD;
        e  = 1'b0;
        f3 = 3'b000;
        f7 = 7'b0000000;
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8: begin
                case (op[3:0])
                    4'd1:    f7 = 7'b0100000;
                    4'd2:    f3 = 3'b111;
                    4'd3:    f3 = 3'b110;
                    4'd4:    f3 = 3'b100;
                    4'd5:    f3 = 3'b001;
                    4'd6:    f3 = 3'b101;
                    4'd7:    begin f3 = 3'b101; f7 = 7'b0100000; end
                    4'd8:    f3 = 3'b010;
                    default: f3 = 3'b000;
                endcase
                w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            5'd9: begin
                w = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
                e = !fits(imm, -2048, 2047);
            end
            5'd10: begin
                w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
                e = !fits(imm, -2048, 2047);
            end
            5'd11: begin
                w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
                e = !fits(imm, -2048, 2047);
            end
            5'd12, 5'd13: begin
                f3 = (op == 5'd13) ? 3'b100 : 3'b000;
                w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
                e  = !fits(imm, -4096, 4094) || imm[0];
            end
            5'd14: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                e = !fits(imm, -1048576, 1048574) || imm[0];
            end
            5'd15: begin
                w = {imm[31:12], rd, 7'b0110111};
                e = |imm[11:0];
            end
            5'd16:   w = 32'h00100073;
            default: e = 1'b1;
        endcase
        return {e, w};
    endfunction

    // Stage p0: combinational encode of the request on the bus
    assign bus.in_ready = (state == S_RUN) && (!vld_p1 || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign enc_p0       = encode(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);

    // Stage p1: registered output word
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            vld_p1     <= 1'b0;
            inst_p1    <= '0;
            addr_p1    <= '0;
            err_p1     <= 1'b0;
            err_sticky <= 1'b0;
            cnt        <= BASE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        cnt        <= BASE;
                        err_sticky <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept && bus.in_op == OP_EBREAK) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
            if (accept) begin
                vld_p1  <= 1'b1;
                inst_p1 <= enc_p0[31:0];
                err_p1  <= enc_p0[32];
                addr_p1 <= cnt;
                cnt     <= cnt + ADDR_W'(4);
                if (enc_p0[32]) err_sticky <= 1'b1;
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_inst  = inst_p1;
    assign bus.out_addr  = addr_p1;
    assign bus.out_err   = err_p1;
    assign done          = (state == S_DONE) && !vld_p1;
endmodule
